mem_access_unit: RTL

- Memory-access stage between the EX_MEM register and the MEM_WB register of the MIPS pipeline.
- Takes the ALU-computed address and store data from EX_MEM and runs a request/acknowledge transaction against a variable-latency data memory.
- Produces aligned, sign- or zero-extended load data for MEM_WB.
- Holds a stall to the upstream pipeline for the duration of each access, and flags misaligned addresses and bus timeouts.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory size encodings and the
// memory-access FSM state type.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    // Size 2'b11 is handled as a word.
    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~lo[0];
            default:   is_aligned = (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension; purely combinational,
// shared by the memory stage and writeback debug logic.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_sh = rdata >> {addr, 3'b000};
        half_sh = rdata >> {addr[1], 4'b0000};
        byte_v  = byte_sh[7:0];
        half_v  = half_sh[15:0];
        result  = rdata;
        case (size)
            SIZE_BYTE: result = {{24{sgn & byte_v[7]}}, byte_v};
            SIZE_HALF: result = {{16{sgn & half_v[15]}}, half_v};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory-access stage: drives a req/ack data-memory transaction,
// stalls upstream while busy and reports misalignment and bus timeouts.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       ReadData,
    output logic              data_valid,
    output logic              misalign,
    output logic              bus_error
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_e      state;
    state_e      state_n;
    logic [7:0]  cnt;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        start;
    logic        ok;
    logic        expire;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ext;

    // The completion cycle still shows the finished instruction in
    // EX_MEM; it must not be issued a second time.
    always_comb begin
        start   = valid_in & (MemRead | MemWrite)
                & (state == ST_IDLE)
                & ~data_valid & ~bus_error;
        ok      = is_aligned(MemSize, ALUResult[1:0]);
        expire  = (state == ST_WAIT) & ~mem_ack & (cnt == LAST);
        stall   = (state == ST_WAIT) | (start & ok);
        state_n = state;
        case (state)
            ST_IDLE: if (start && ok) state_n = ST_WAIT;
            ST_WAIT: if (mem_ack || expire) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = WriteData;
        case (MemSize)
            SIZE_BYTE: begin
                be    = 4'b0001 << ALUResult[1:0];
                wdata = {4{WriteData[7:0]}};
            end
            SIZE_HALF: begin
                be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (lane_q),
        .size   (size_q),
        .sgn    (sgn_q),
        .result (ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            ReadData   <= '0;
            data_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_error  <= 1'b0;
            cnt        <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_error  <= 1'b0;
            if (start && !ok) begin
                misalign <= 1'b1;
            end else if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite & ~MemRead;
                mem_addr  <= ADDR_W'({ALUResult[31:2], 2'b00});
                mem_be    <= be;
                mem_wdata <= wdata;
                cnt       <= '0;
                lane_q    <= ALUResult[1:0];
                size_q    <= MemSize;
                sgn_q     <= MemSigned;
            end else if (state == ST_WAIT) begin
                if (mem_ack) begin
                    mem_req    <= 1'b0;
                    data_valid <= 1'b1;
                    if (!mem_we) ReadData <= ext;
                end else if (expire) begin
                    mem_req   <= 1'b0;
                    ReadData  <= '0;
                    bus_error <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule
